arduino_cmd_uart_rx: RTL and testbench
======================================

// Module: arduino_cmd_uart_rx
// PURPOSE
//  Serial front end for manual driving. Receives 8N1 UART bytes from the Arduino
//  remote and validates each one as a drive command. Holds the last good command
//  on arduino_command, which feeds manual_mode directly.
//  A link watchdog forces the command to 8'h00 (stop) when the remote goes silent.
// PARAMETERS
//  CLK_FREQ    50_000_000  system clock frequency, Hz
//  BAUD        9600        UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division)
//  TIMEOUT_MS  200         silence time before forced stop; TIMEOUT_CLKS = CLK_FREQ/1000*TIMEOUT_MS
// PORTS
//  clk              in   1  system clock
//  rst_n            in   1  asynchronous reset, active low
//  uart_rx          in   1  serial line from the Arduino; idles high; asynchronous to clk
//  arduino_command  out  8  last accepted command; bits[3:0] = {right,back,left,fwd}
//  cmd_valid        out  1  1-cycle pulse when arduino_command is (re)loaded
//  frame_err        out  1  1-cycle pulse on bad stop bit (or bad parity, see CONFIGURATION)
//  cmd_err          out  1  1-cycle pulse on a well-framed byte with a nonzero upper nibble
//  link_ok          out  1  high while a valid command was accepted within TIMEOUT_CLKS
// BEHAVIOUR
//  Reset: arduino_command=8'h00, cmd_valid=0, frame_err=0, cmd_err=0, link_ok=0.
//   Synchronizers are reset to 1. FSM is in IDLE. All counters are 0.
//  uart_rx passes through a 2-FF synchronizer. All logic below uses the synced bit, rx_s.
//  FSM states and transitions:
//   IDLE: on rx_s==0 -> START and clear bit_cnt.
//   START: wait CLKS_PER_BIT/2 clocks, then resample.
//    If rx_s==1, it was a glitch -> IDLE with no error.
//    If rx_s==0 -> DATA and clear bit_cnt.
//   DATA: sample every CLKS_PER_BIT clocks. Data is LSB first into shift_reg.
//    After the 8th sample -> STOP (or PARITY when the parity option is built in).
//   STOP: sample after CLKS_PER_BIT clocks.
//    rx_s==0: pulse frame_err, byte discarded -> WAIT_HIGH.
//    rx_s==1 with shift_reg[7:4]!=0: pulse cmd_err, byte discarded -> IDLE.
//    Otherwise: load arduino_command<=shift_reg and pulse cmd_valid -> IDLE.
//   WAIT_HIGH: stay until rx_s==1 (handles a break or stuck-low line) -> IDLE.
//  Timing: cmd_valid, frame_err and cmd_err assert on the clock after the stop sample.
//   Latency from the uart_rx falling edge is 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clks.
//  Error pulses never change arduino_command. A repeated identical byte still pulses
//   cmd_valid.
//  Watchdog counter wd_cnt:
//   Clears to 0 and sets link_ok=1 on every cmd_valid.
//   Otherwise increments and saturates at TIMEOUT_CLKS.
//   When wd_cnt reaches TIMEOUT_CLKS: arduino_command<=8'h00 and link_ok<=0 in the same
//    cycle. The forced stop does not pulse cmd_valid.
//   Errors do not reset the watchdog.
//   If cmd_valid coincides with expiry, cmd_valid wins: the new command is loaded and
//    link_ok stays 1.
//  rst_n asserted mid-frame: immediate return to the reset state; the partial byte is lost.
// CONFIGURATION
//  CMD_PARITY_EN defined: frame is 8E1. A PARITY state follows DATA and samples one bit.
//   If (^shift_reg ^ parity_bit) != 0: pulse frame_err -> WAIT_HIGH. Otherwise -> STOP.
//   Latency grows by CLKS_PER_BIT.
//  CMD_PARITY_EN undefined: frame is 8N1, the PARITY state is absent, and behaviour is
//   exactly as above.
// TESTING  (CLK_FREQ=1_000_000, BAUD=100_000 -> 10 clks/bit; TIMEOUT_MS=1 -> 1000 clks)
//  1 Reset with line idle: all outputs 0. Send 8'h01: one cmd_valid pulse;
//    arduino_command=8'h01; link_ok=1.
//  2 Send 8'h03, 8'h09, 8'h05, 8'h0C back to back: command follows each byte;
//    exactly four cmd_valid pulses.
//  3 Send 8'h41: one cmd_err pulse; command stays at the previous value; no cmd_valid.
//  4 Send 8'h04 with the stop bit driven 0, then hold the line low for 30 clks:
//    one frame_err pulse; FSM stays in WAIT_HIGH; no new byte until the line is high.
//  5 Drive a 3-clk low glitch on an idle line: no pulses; FSM is back in IDLE.
//  6 Send 8'h02, then idle for 1000 clks: arduino_command=8'h00 and link_ok=0 exactly
//    TIMEOUT_CLKS after cmd_valid. Send 8'h08: link_ok=1 and command=8'h08.

Source files
------------

// File: rtl/arduino_cmd_uart_rx.sv
// UART command receiver for the Arduino manual-drive remote. It receives
// 8N1 frames, or 8E1 frames when CMD_PARITY_EN is defined, through a 2-FF
// synchronizer. The last well-formed drive command is held on arduino_command.
// Latency: 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clks from the start-bit
// falling edge to cmd_valid. Parity adds one more bit time.
// Backpressure: none. The serial line cannot be stalled, so every result is a
// single-cycle pulse.
// Ports:
//   clk, rst_n (async, active low)
//   uart_rx: serial input, idles high
//   arduino_command[7:0]: last good command; bits[3:0] = {right,back,left,fwd}
//   cmd_valid, frame_err, cmd_err: 1-cycle result pulses
//   link_ok: a valid command was seen within TIMEOUT_CLKS
// Optional feature macro: CMD_PARITY_EN (even parity bit after the data bits).
module arduino_cmd_uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int TIMEOUT_MS = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] arduino_command,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       cmd_err,
  output logic       link_ok
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TIMEOUT_CLKS = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int WD_W         = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(TIMEOUT_CLKS);
  localparam logic [WD_W-1:0]  WD_PRE    = WD_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef CMD_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state, state_nxt;
  logic             rx_m, rx_s;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shift_reg, shift_nxt;
  logic [WD_W-1:0]  wd_cnt;
  logic             accept, ferr_set, cerr_set;

  // Next-state and sampling control. clk_cnt times the half-bit delay in START
  // and the full bit periods after that, so every later sample falls mid-bit.
  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt + 1'b1;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_reg;
    accept      = 1'b0;
    ferr_set    = 1'b0;
    cerr_set    = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_nxt = '0;
        if (!rx_s) begin
          state_nxt   = START;
          bit_cnt_nxt = '0;
        end
      end
      START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          // A line that is high again at mid-start-bit was only a glitch.
          state_nxt   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nxt = '0;
          shift_nxt   = {rx_s, shift_reg[7:1]};
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef CMD_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef CMD_PARITY_EN
      PARITY: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nxt = '0;
          if ((^shift_reg) ^ rx_s) begin
            ferr_set  = 1'b1;
            state_nxt = WAIT_HIGH;
          end else begin
            state_nxt = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nxt = '0;
          if (!rx_s) begin
            ferr_set  = 1'b1;
            state_nxt = WAIT_HIGH;
          end else if (shift_reg[7:4] != 4'h0) begin
            cerr_set  = 1'b1;
            state_nxt = IDLE;
          end else begin
            accept    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      WAIT_HIGH: begin
        clk_cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      rx_m      <= uart_rx;
      rx_s      <= rx_m;
      state     <= state_nxt;
      clk_cnt   <= clk_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_nxt;
      cmd_valid <= accept;
      frame_err <= ferr_set;
      cmd_err   <= cerr_set;
    end
  end

  // Link watchdog. An accepted command always wins over expiry. Expiry zeroes
  // the command on the same edge that wd_cnt reaches TIMEOUT_CLKS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arduino_command <= 8'h00;
      wd_cnt          <= '0;
      link_ok         <= 1'b0;
    end else if (accept) begin
      arduino_command <= shift_reg;
      wd_cnt          <= '0;
      link_ok         <= 1'b1;
    end else if (wd_cnt != WD_MAX) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == WD_PRE) begin
        arduino_command <= 8'h00;
        link_ok         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arduino_cmd_uart_rx.sv
module tb_arduino_cmd_uart_rx;

  localparam int CLK_FREQ     = 1_000_000;
  localparam int BAUD         = 100_000;
  localparam int TIMEOUT_MS   = 1;
  localparam int CPB          = CLK_FREQ / BAUD;
  localparam int TIMEOUT_CLKS = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int LATENCY      = 2 + CPB / 2 + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] arduino_command;
  logic       cmd_valid, frame_err, cmd_err, link_ok;

  arduino_cmd_uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .TIMEOUT_MS(TIMEOUT_MS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .uart_rx        (uart_rx),
    .arduino_command(arduino_command),
    .cmd_valid      (cmd_valid),
    .frame_err      (frame_err),
    .cmd_err        (cmd_err),
    .link_ok        (link_ok)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters observed from the DUT.
  int n_valid = 0, n_ferr = 0, n_cerr = 0, last_valid_cyc = -1;
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid) begin
        n_valid++;
        last_valid_cyc = cyc;
      end
      if (frame_err) n_ferr++;
      if (cmd_err) n_cerr++;
    end
  end

  // Reference model: what the remote link should look like, byte by byte.
  int         exp_valid = 0, exp_ferr = 0, exp_cerr = 0;
  bit         have_acc = 1'b0;
  logic [7:0] last_cmd = 8'h00;
  int         last_acc = 0;

  int errors = 0, checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit exp_link(input int now);
    return have_acc && ((now - last_acc) < TIMEOUT_CLKS);
  endfunction

  // Sends one frame. It returns #1 after the edge that ends the stop bit, with
  // the line left at the stop-bit level.
  task automatic send_byte(input logic [7:0] d, input logic stop, output int t0);
    logic [9:0] frame;
    frame = {stop, d, 1'b0};
    @(posedge clk);
    #1;
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      uart_rx = frame[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    if (!stop) begin
      exp_ferr++;
    end else if (d[7:4] != 4'h0) begin
      exp_cerr++;
    end else begin
      exp_valid++;
      have_acc = 1'b1;
      last_cmd = d;
      last_acc = t0 + LATENCY;
    end
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    check_val({tag, ".n_valid"}, n_valid, exp_valid);
    check_val({tag, ".n_ferr"}, n_ferr, exp_ferr);
    check_val({tag, ".n_cerr"}, n_cerr, exp_cerr);
    check_val({tag, ".cmd"}, arduino_command, exp_link(cyc) ? last_cmd : 8'h00);
    check_val({tag, ".link_ok"}, link_ok, exp_link(cyc));
  endtask

  int         t0, target;
  logic [7:0] d;
  logic       stop;
  logic [7:0] seq2 [4] = '{8'h03, 8'h09, 8'h05, 8'h0C};

  initial begin
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_val("rst.cmd", arduino_command, 8'h00);
    check_val("rst.cmd_valid", cmd_valid, 1'b0);
    check_val("rst.frame_err", frame_err, 1'b0);
    check_val("rst.cmd_err", cmd_err, 1'b0);
    check_val("rst.link_ok", link_ok, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // First command and its exact latency.
    send_byte(8'h01, 1'b1, t0);
    check_state("t1");
    check_val("t1.latency", last_valid_cyc - t0, LATENCY);

    // Back-to-back commands.
    foreach (seq2[i]) begin
      send_byte(seq2[i], 1'b1, t0);
      check_state("t2");
    end

    // Upper nibble set: rejected as a command.
    send_byte(8'h41, 1'b1, t0);
    check_state("t3");

    // Bad stop bit, then the line is held low: no frame may start until it goes high.
    send_byte(8'h04, 1'b0, t0);
    repeat (30) @(posedge clk);
    #1;
    check_state("t4.low");
    uart_rx = 1'b1;
    repeat (150) @(posedge clk);
    check_state("t4.high");

    // Short glitch on an idle line.
    @(posedge clk);
    #1;
    uart_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (20) @(posedge clk);
    check_state("t5");

    // Watchdog expiry, checked exactly on both sides of the boundary.
    send_byte(8'h02, 1'b1, t0);
    check_state("t6.load");
    target = t0 + LATENCY + TIMEOUT_CLKS - 1;
    while (cyc < target) @(negedge clk);
    check_val("t6.pre.link_ok", link_ok, 1'b1);
    check_val("t6.pre.cmd", arduino_command, 8'h02);
    @(negedge clk);
    check_val("t6.exp.link_ok", link_ok, 1'b0);
    check_val("t6.exp.cmd", arduino_command, 8'h00);
    check_val("t6.exp.n_valid", n_valid, exp_valid);
    send_byte(8'h08, 1'b1, t0);
    check_state("t6.relink");

    // Reset in the middle of a frame.
    @(posedge clk);
    #1;
    uart_rx = 1'b0;
    repeat (35) @(posedge clk);
    #1;
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    have_acc = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("mid_rst.cmd", arduino_command, 8'h00);
    check_val("mid_rst.link_ok", link_ok, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    check_state("mid_rst.after");

    // Random traffic.
    for (int n = 0; n < 30; n++) begin
      d    = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      stop = ($urandom_range(0, 5) != 0);
      send_byte(d, stop, t0);
      check_state("rnd");
      if (!stop) begin
        repeat ($urandom_range(0, 20)) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (20) @(posedge clk);
      end else begin
        repeat ($urandom_range(0, 30)) @(posedge clk);
      end
    end
    check_state("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
